pipe_stage_reg: RTL and testbench

- Parametrised fetch-to-decode pipeline stage register: carries an instruction word and its PC between pipeline stages.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, and a flush with priority over all traffic.
- Adds saturating stall and flush event counters for debug.
- Drops in between any two pipeline stages in place of the fixed 32-bit enable/clear stage registers.

---
 rtl/pipe_stage_reg_if.sv | 21 ++
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready pipeline bus carrying one instruction word and its PC.
// The master drives the entry; the slave answers with ready.
interface pipe_stage_reg_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    logic               valid;
    logic               ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;

    modport master (
        output valid, instr, pc,
        input  ready
    );

    modport slave (
        input  valid, instr, pc,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Fetch-to-decode stage register with valid/ready handshake, optional
// 2-entry skid buffer, priority flush and saturating debug counters.
module pipe_stage_reg #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    pipe_stage_reg_if.slave     in_if,
    pipe_stage_reg_if.master    out_if,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    flush_cnt_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;

    logic out_valid;
    logic in_ready;
    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != S_EMPTY);

    // With a skid buffer, ready is a pure function of the state register
    generate
        if (SKID != 0) begin : g_skid_rdy
            assign in_ready = (state_q != S_SKID);
        end else begin : g_pass_rdy
            assign in_ready = !out_valid || out_if.ready;
        end
    endgenerate

    assign in_xfer  = in_if.valid && in_ready;
    assign out_xfer = out_valid && out_if.ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        unique case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    state_d      = S_FULL;
                    main_instr_d = in_if.instr;
                    main_pc_d    = in_if.pc;
                end
            end
            S_FULL: begin
                if (in_xfer && out_xfer) begin
                    main_instr_d = in_if.instr;
                    main_pc_d    = in_if.pc;
                end else if (in_xfer && SKID != 0) begin
                    state_d      = S_SKID;
                    skid_instr_d = in_if.instr;
                    skid_pc_d    = in_if.pc;
                end else if (out_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_SKID: begin
                if (out_xfer) begin
                    state_d      = S_FULL;
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush_i) begin
            state_d      = S_EMPTY;
            main_instr_d = '0;
            main_pc_d    = '0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        fcnt_d  = fcnt_q;
        if (!flush_i && out_valid && !out_if.ready && stall_q != CNT_MAX)
            stall_d = stall_q + CNT_W'(1);
        if (flush_i && out_valid && fcnt_q != CNT_MAX)
            fcnt_d = fcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_EMPTY;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            stall_q      <= '0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            stall_q      <= stall_d;
            fcnt_q       <= fcnt_d;
        end
    end

    // Bubbles read as zero so downstream sees a NOP
    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.instr = out_valid ? main_instr_q : '0;
    assign out_if.pc    = out_valid ? main_pc_q : '0;
    assign stall_cnt_o  = stall_q;
    assign flush_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid instance (CNT_W=4) and a pass-through instance.
// Expected values are hand-computed constants per step.
module tb_pipe_stage_reg;

    logic clk;
    logic reset;
    logic flush;
    logic [3:0]  a_stall, a_flush;
    logic [15:0] b_stall, b_flush;

    int n_assert;
    int n_fail;

    pipe_stage_reg_if #(.INSTR_W(32), .PC_W(32)) a_in ();
    pipe_stage_reg_if #(.INSTR_W(32), .PC_W(32)) a_out ();
    pipe_stage_reg_if #(.INSTR_W(32), .PC_W(32)) b_in ();
    pipe_stage_reg_if #(.INSTR_W(32), .PC_W(32)) b_out ();

    pipe_stage_reg #(
        .INSTR_W(32), .PC_W(32), .SKID(1), .CNT_W(4)
    ) dut_a (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .in_if       (a_in),
        .out_if      (a_out),
        .stall_cnt_o (a_stall),
        .flush_cnt_o (a_flush)
    );

    pipe_stage_reg #(
        .INSTR_W(32), .PC_W(32), .SKID(0), .CNT_W(16)
    ) dut_b (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .in_if       (b_in),
        .out_if      (b_out),
        .stall_cnt_o (b_stall),
        .flush_cnt_o (b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic v, input logic [31:0] ins,
                           input logic [31:0] pc);
        a_in.valid = v;
        a_in.instr = ins;
        a_in.pc    = pc;
    endtask

    task automatic b_drive(input logic v, input logic [31:0] ins,
                           input logic [31:0] pc);
        b_in.valid = v;
        b_in.instr = ins;
        b_in.pc    = pc;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        flush    = 1'b0;
        a_out.ready = 1'b1;
        b_out.ready = 1'b1;
        b_drive(1'b0, 32'h0, 32'h0);
        a_drive(1'b1, 32'hE3A00001, 32'h1000);

        // reset hold
        tick();
        tick();
        chk("rst_valid", a_out.valid, 0);
        chk("rst_instr", a_out.instr, 0);
        chk("rst_pc", a_out.pc, 0);
        chk("rst_ready", a_in.ready, 1);
        chk("rst_stall", a_stall, 0);
        chk("rst_flush", a_flush, 0);
        chk("rst_b_ready", b_in.ready, 1);
        reset = 1'b0;
        tick();
        chk("post_rst_valid", a_out.valid, 1);
        chk("post_rst_instr", a_out.instr, 32'hE3A00001);
        chk("post_rst_pc", a_out.pc, 32'h1000);

        // streaming
        for (int i = 0; i < 5; i++) begin
            a_drive(1'b1, 32'h100 + 32'(i), 32'(4 * i));
            tick();
            chk("strm_valid", a_out.valid, 1);
            chk("strm_instr", a_out.instr, 32'h100 + 32'(i));
            chk("strm_pc", a_out.pc, 32'(4 * i));
            chk("strm_ready", a_in.ready, 1);
        end
        a_drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("strm_end_valid", a_out.valid, 0);
        chk("strm_end_instr", a_out.instr, 0);
        chk("strm_stall", a_stall, 0);

        // skid fill and drain
        a_out.ready = 1'b0;
        a_drive(1'b1, 32'hAAAA0000, 32'h20);
        tick();
        chk("skA_instr", a_out.instr, 32'hAAAA0000);
        chk("skA_ready", a_in.ready, 1);
        a_drive(1'b1, 32'hBBBB0000, 32'h24);
        tick();
        chk("skB_ready", a_in.ready, 0);
        chk("skB_instr", a_out.instr, 32'hAAAA0000);
        chk("skB_pc", a_out.pc, 32'h20);
        chk("skB_stall", a_stall, 1);
        a_drive(1'b1, 32'hCCCC0000, 32'h28);
        tick();
        chk("skC_hold_instr", a_out.instr, 32'hAAAA0000);
        chk("skC_hold_ready", a_in.ready, 0);
        chk("skC_stall", a_stall, 2);
        a_out.ready = 1'b1;
        tick();
        chk("drain_B_instr", a_out.instr, 32'hBBBB0000);
        chk("drain_B_pc", a_out.pc, 32'h24);
        chk("drain_B_ready", a_in.ready, 1);
        tick();
        chk("drain_C_instr", a_out.instr, 32'hCCCC0000);
        chk("drain_C_pc", a_out.pc, 32'h28);
        a_drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("drain_end_valid", a_out.valid, 0);
        chk("drain_stall", a_stall, 2);

        // flush while in skid state
        a_out.ready = 1'b0;
        a_drive(1'b1, 32'hAAAA0000, 32'h20);
        tick();
        a_drive(1'b1, 32'hBBBB0000, 32'h24);
        tick();
        chk("fl_pre_ready", a_in.ready, 0);
        chk("fl_pre_stall", a_stall, 3);
        flush = 1'b1;
        a_drive(1'b1, 32'hDEAD0000, 32'h99);
        tick();
        chk("fl_valid", a_out.valid, 0);
        chk("fl_instr", a_out.instr, 0);
        chk("fl_pc", a_out.pc, 0);
        chk("fl_ready", a_in.ready, 1);
        chk("fl_cnt", a_flush, 1);
        chk("fl_stall", a_stall, 3);
        flush = 1'b0;
        a_drive(1'b0, 32'h0, 32'h0);
        a_out.ready = 1'b1;
        tick();
        chk("fl_after_valid", a_out.valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty_cnt", a_flush, 1);
        chk("fl_b_cnt", b_flush, 0);

        // stall counter saturation
        a_out.ready = 1'b0;
        a_drive(1'b1, 32'h5A5A0000, 32'h30);
        tick();
        a_drive(1'b0, 32'h0, 32'h0);
        chk("sat_start", a_stall, 3);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", a_stall, 15);
        chk("sat_valid", a_out.valid, 1);
        chk("sat_instr", a_out.instr, 32'h5A5A0000);
        tick();
        chk("sat_stay", a_stall, 15);
        a_out.ready = 1'b1;
        tick();
        chk("sat_drain", a_out.valid, 0);

        // pass-through instance
        b_drive(1'b1, 32'h11, 32'h40);
        #1;
        chk("b_rdy_empty", b_in.ready, 1);
        tick();
        chk("b_e1_instr", b_out.instr, 32'h11);
        b_out.ready = 1'b0;
        b_drive(1'b1, 32'h22, 32'h44);
        #1;
        chk("b_rdy_stall", b_in.ready, 0);
        tick();
        chk("b_hold_instr", b_out.instr, 32'h11);
        chk("b_hold_pc", b_out.pc, 32'h40);
        b_out.ready = 1'b1;
        #1;
        chk("b_rdy_go", b_in.ready, 1);
        tick();
        chk("b_e2_instr", b_out.instr, 32'h22);
        chk("b_e2_pc", b_out.pc, 32'h44);
        b_drive(1'b1, 32'h33, 32'h48);
        tick();
        chk("b_e3_instr", b_out.instr, 32'h33);
        chk("b_e3_pc", b_out.pc, 32'h48);
        b_drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("b_end_valid", b_out.valid, 0);
        chk("b_stall", b_stall, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
